// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC receive datapath.
// Holds frame-size limits, the good-FCS status code and the receive FSM state type.
package mac_pkg;

  localparam int unsigned FCS_BYTES        = 4;
  localparam int unsigned ETH_MAX_FRAME    = 1518;
  localparam int unsigned MIN_COMMIT_BYTES = 5;

  localparam logic [1:0] CRC_GOOD = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RX      = 2'd1,
    DISCARD = 2'd2
  } rx_state_t;

endpackage

// File: rtl/mac_rx_slotbuf_if.sv
// Bus bundle between the PHY-side nibble stream, the packet consumer and mac_rx_slotbuf.
// Stream:      in_valid, in_data (beat, or FCS status in the cycle after the frame)
// Ready queue: rdy_valid, rdy_slot, rdy_len, rdy_ack
// Read port:   rd_slot, rd_addr -> rd_data (one-cycle latency)
// Drops:       drop_pulse, drop_count
// master = the environment driving frames and consuming them; slave = the buffer.
interface mac_rx_slotbuf_if #(
  parameter int unsigned DW = 2,
  parameter int unsigned AW = 11,
  parameter int unsigned SW = 1
);

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          rdy_valid;
  logic [SW-1:0] rdy_slot;
  logic [AW:0]   rdy_len;
  logic          rdy_ack;
  logic [SW-1:0] rd_slot;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          drop_pulse;
  logic [15:0]   drop_count;

  modport master (
    output in_valid, in_data, rdy_ack, rd_slot, rd_addr,
    input  rdy_valid, rdy_slot, rdy_len, rd_data, drop_pulse, drop_count
  );

  modport slave (
    input  in_valid, in_data, rdy_ack, rd_slot, rd_addr,
    output rdy_valid, rdy_slot, rdy_len, rd_data, drop_pulse, drop_count
  );

endinterface

// File: rtl/mac_rx_slot_ram.sv
// Simple dual-port byte RAM holding all frame slots, addressed {slot, byte}.
// Ports: clk, rst (clears only the read register), wr_en/wr_addr/wr_data write port,
//        rd_addr -> rd_data registered read port.
module mac_rx_slot_ram #(
  parameter int unsigned AW = 11,
  parameter int unsigned SW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [SW+AW-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic [SW+AW-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  localparam int unsigned DEPTH = 1 << (SW + AW);

  logic [7:0] mem [DEPTH];

  // Write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mac_rx_slotbuf.sv
// Receive frame buffer: assembles DW-bit beats LSB-first into bytes, stores each frame
// in one of SLOTS slots, commits good frames to an in-order ready queue and counts drops.
// Ports: clk, rst (sync, active-high), bus (mac_rx_slotbuf_if.slave).
module mac_rx_slotbuf
  import mac_pkg::*;
#(
  parameter int unsigned DW        = 2,
  parameter int unsigned MAX_BYTES = ETH_MAX_FRAME,
  parameter int unsigned SLOTS     = 2
) (
  input  logic            clk,
  input  logic            rst,
  mac_rx_slotbuf_if.slave bus
);

  localparam int unsigned AW  = $clog2(MAX_BYTES);
  localparam int unsigned SW  = $clog2(SLOTS);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned BPB = 8 / DW;
  localparam int unsigned LW  = (BPB > 1) ? $clog2(BPB) : 1;

  rx_state_t     state;
  logic [CW-1:0] addr;
  logic [LW-1:0] lane;
  logic [7:0]    byte_buf;
  logic [SW-1:0] wr_ptr;
  logic [SW-1:0] head_ptr;
  logic [SW:0]   nready;
  logic [CW-1:0] len_mem [SLOTS];

  logic          beat_c;
  logic          byte_done_c;
  logic          wr_en_c;
  logic          commit_c;
  logic          drop_c;
  logic          ack_c;
  logic [7:0]    asm_c;
  logic [SW-1:0] head_n_c;
  logic [SW:0]   nready_n_c;
  logic [CW-1:0] commit_len_c;

  // Beat acceptance, status decision and queue next-values.
  always_comb begin
    asm_c        = byte_buf;
    beat_c       = 1'b0;
    commit_c     = 1'b0;
    drop_c       = 1'b0;
    for (int unsigned k = 0; k < BPB; k++) begin
      if (lane == LW'(k)) asm_c[k*DW +: DW] = bus.in_data;
    end
    byte_done_c  = (lane == LW'(BPB - 1));
    case (state)
      // addr and lane are zero here, so the first beat lands in lane 0 of byte 0.
      IDLE:    beat_c = bus.in_valid && (nready < (SW+1)'(SLOTS));
      RX: begin
        if (bus.in_valid) begin
          beat_c = (addr != CW'(MAX_BYTES));
        end else if (bus.in_data[1:0] == CRC_GOOD && lane == '0 &&
                     addr >= CW'(MIN_COMMIT_BYTES)) begin
          commit_c = 1'b1;
        end else begin
          drop_c = 1'b1;
        end
      end
      DISCARD: drop_c = !bus.in_valid;
      default: ;
    endcase
    wr_en_c      = beat_c && byte_done_c;
    ack_c        = bus.rdy_ack && (nready != '0);
    head_n_c     = ack_c ? head_ptr + 1'b1 : head_ptr;
    nready_n_c   = nready + (SW+1)'(commit_c) - (SW+1)'(ack_c);
    commit_len_c = addr - CW'(FCS_BYTES);
  end

  // Receive FSM, queue pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      addr           <= '0;
      lane           <= '0;
      byte_buf       <= '0;
      wr_ptr         <= '0;
      head_ptr       <= '0;
      nready         <= '0;
      bus.rdy_valid  <= 1'b0;
      bus.rdy_slot   <= '0;
      bus.rdy_len    <= '0;
      bus.drop_pulse <= 1'b0;
      bus.drop_count <= '0;
    end else begin
      case (state)
        IDLE:    if (bus.in_valid) state <= beat_c ? RX : DISCARD;
        RX:      if (!bus.in_valid) state <= IDLE;
                 else if (!beat_c) state <= DISCARD;
        DISCARD: if (!bus.in_valid) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (beat_c) begin
        byte_buf <= asm_c;
        if (byte_done_c) begin
          lane <= '0;
          addr <= addr + 1'b1;
        end else begin
          lane <= lane + 1'b1;
        end
      end else if (state != IDLE && !bus.in_valid) begin
        addr <= '0;
        lane <= '0;
      end

      if (commit_c) wr_ptr <= wr_ptr + 1'b1;
      head_ptr <= head_n_c;
      nready   <= nready_n_c;

      bus.rdy_valid <= (nready_n_c != '0);
      bus.rdy_slot  <= head_n_c;
      // A commit into an empty queue becomes the head in the same edge.
      bus.rdy_len   <= (commit_c && wr_ptr == head_n_c) ? commit_len_c : len_mem[head_n_c];

      bus.drop_pulse <= drop_c;
      if (drop_c && bus.drop_count != 16'hFFFF) bus.drop_count <= bus.drop_count + 1'b1;
    end
  end

  // Per-slot committed lengths.
  always_ff @(posedge clk) begin
    if (commit_c) len_mem[wr_ptr] <= commit_len_c;
  end

  mac_rx_slot_ram #(.AW(AW), .SW(SW)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_c),
    .wr_addr ({wr_ptr, addr[AW-1:0]}),
    .wr_data (asm_c),
    .rd_addr ({bus.rd_slot, bus.rd_addr}),
    .rd_data (bus.rd_data)
  );

endmodule

// File: tb/tb_mac_rx_slotbuf.sv
// Directed bench for mac_rx_slotbuf: a DW=2 instance for the frame table, queue-full,
// back-to-back, commit+ack and oversize cases, and a DW=4 instance for readback and
// mid-frame reset.
module tb_mac_rx_slotbuf;
  import mac_pkg::*;

  localparam int unsigned AW = 11;
  localparam int unsigned SW = 1;

  logic clk = 1'b0;
  logic rst2;
  logic rst4;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mac_rx_slotbuf_if #(.DW(2), .AW(AW), .SW(SW)) b2 ();
  mac_rx_slotbuf_if #(.DW(4), .AW(AW), .SW(SW)) b4 ();

  mac_rx_slotbuf #(.DW(2), .MAX_BYTES(1518), .SLOTS(2)) dut (
    .clk(clk), .rst(rst2), .bus(b2.slave)
  );

  mac_rx_slotbuf #(.DW(4), .MAX_BYTES(1518), .SLOTS(2)) dut4 (
    .clk(clk), .rst(rst4), .bus(b4.slave)
  );

  typedef struct {
    string      name;
    int         nbytes;
    int         base;
    int         extra;
    logic [1:0] status;
    bit         commit;
    int         len;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v, input logic [3:0] d);
    if (!sel) begin b2.in_valid = v; b2.in_data = d[1:0]; end
    else      begin b4.in_valid = v; b4.in_data = d;      end
  endtask

  task automatic set_ack(input bit sel, input logic a);
    if (!sel) b2.rdy_ack = a;
    else      b4.rdy_ack = a;
  endtask

  // Bytes base+i, LSB beat first; returns in the cycle after the status cycle.
  task automatic send_frame(input bit sel, input int nbytes, input int base, input int extra,
                            input logic [1:0] status, input bit ack_st);
    int dw;
    dw = sel ? 4 : 2;
    for (int i = 0; i < nbytes; i++) begin
      logic [7:0] bv;
      bv = 8'(base + i);
      for (int k = 0; k < 8 / dw; k++) begin
        drive(sel, 1'b1, 4'(bv >> (k * dw)));
        step();
      end
    end
    for (int k = 0; k < extra; k++) begin
      drive(sel, 1'b1, 4'(k));
      step();
    end
    drive(sel, 1'b0, {2'b00, status});
    if (ack_st) set_ack(sel, 1'b1);
    step();
    drive(sel, 1'b0, 4'h0);
    set_ack(sel, 1'b0);
  endtask

  task automatic read_chk(input bit sel, input int slot, input int addr, input int exp,
                          input string name);
    if (!sel) begin b2.rd_slot = SW'(slot); b2.rd_addr = AW'(addr); end
    else      begin b4.rd_slot = SW'(slot); b4.rd_addr = AW'(addr); end
    step();
    chk(name, sel ? int'(b4.rd_data) : int'(b2.rd_data), exp & 255);
  endtask

  task automatic ack_once(input bit sel);
    set_ack(sel, 1'b1);
    step();
    set_ack(sel, 1'b0);
  endtask

  initial begin
    int model_wr;
    int exp_drops;
    bit saw_drop;

    vecs[0] = '{"good64",     64, 8'h00, 0, 2'b11, 1'b1, 60};
    vecs[1] = '{"bad_fcs",    64, 8'h00, 0, 2'b01, 1'b0, 0};
    vecs[2] = '{"runt4",       4, 8'h11, 0, 2'b11, 1'b0, 0};
    vecs[3] = '{"min5",        5, 8'h30, 0, 2'b11, 1'b1, 1};
    vecs[4] = '{"odd_dibits", 15, 8'h00, 3, 2'b11, 1'b0, 0};
    vecs[5] = '{"status10",   16, 8'h00, 0, 2'b10, 1'b0, 0};

    rst2 = 1'b1; rst4 = 1'b1;
    b2.in_valid = 1'b0; b2.in_data = '0; b2.rdy_ack = 1'b0; b2.rd_slot = '0; b2.rd_addr = '0;
    b4.in_valid = 1'b0; b4.in_data = '0; b4.rdy_ack = 1'b0; b4.rd_slot = '0; b4.rd_addr = '0;
    repeat (3) step();
    chk("rst rdy_valid",  b2.rdy_valid,  0);
    chk("rst rdy_slot",   b2.rdy_slot,   0);
    chk("rst rdy_len",    b2.rdy_len,    0);
    chk("rst rd_data",    b2.rd_data,    0);
    chk("rst drop_pulse", b2.drop_pulse, 0);
    chk("rst drop_count", b2.drop_count, 0);
    rst2 = 1'b0; rst4 = 1'b0;
    step();

    // Single-frame table with the queue drained after each commit.
    model_wr  = 0;
    exp_drops = 0;
    for (int i = 0; i < 6; i++) begin
      send_frame(1'b0, vecs[i].nbytes, vecs[i].base, vecs[i].extra, vecs[i].status, 1'b0);
      if (!vecs[i].commit) exp_drops++;
      chk({vecs[i].name, " rdy_valid"},  b2.rdy_valid,  int'(vecs[i].commit));
      chk({vecs[i].name, " drop_pulse"}, b2.drop_pulse, int'(!vecs[i].commit));
      chk({vecs[i].name, " drop_count"}, b2.drop_count, exp_drops);
      if (vecs[i].commit) begin
        chk({vecs[i].name, " rdy_slot"}, b2.rdy_slot, model_wr);
        chk({vecs[i].name, " rdy_len"},  b2.rdy_len,  vecs[i].len);
        for (int a = 0; a < vecs[i].len; a++)
          read_chk(1'b0, model_wr, a, vecs[i].base + a, {vecs[i].name, " rd_data"});
        model_wr = (model_wr + 1) % 2;
        ack_once(1'b0);
        chk({vecs[i].name, " rdy_valid after ack"}, b2.rdy_valid, 0);
      end else begin
        step();
        chk({vecs[i].name, " drop_pulse width"}, b2.drop_pulse, 0);
      end
    end

    // Queue full: A and B back to back, C finds no free slot.
    send_frame(1'b0, 16, 8'h40, 0, 2'b11, 1'b0);
    chk("full A rdy_valid", b2.rdy_valid, 1);
    chk("full A rdy_slot",  b2.rdy_slot,  0);
    chk("full A rdy_len",   b2.rdy_len,   12);
    send_frame(1'b0, 20, 8'h80, 0, 2'b11, 1'b0);
    chk("b2b B drop_pulse", b2.drop_pulse, 0);
    chk("full B rdy_slot",  b2.rdy_slot,  0);
    chk("full B rdy_len",   b2.rdy_len,   12);
    send_frame(1'b0, 10, 8'hC0, 0, 2'b11, 1'b0);
    exp_drops++;
    chk("full C drop_pulse", b2.drop_pulse, 1);
    chk("full C drop_count", b2.drop_count, exp_drops);
    ack_once(1'b0);
    chk("ack1 rdy_valid", b2.rdy_valid, 1);
    chk("ack1 rdy_slot",  b2.rdy_slot,  1);
    chk("ack1 rdy_len",   b2.rdy_len,   16);
    send_frame(1'b0, 24, 8'h10, 0, 2'b11, 1'b0);
    chk("D drop_pulse", b2.drop_pulse, 0);
    ack_once(1'b0);
    chk("D rdy_slot", b2.rdy_slot, 0);
    chk("D rdy_len",  b2.rdy_len,  20);
    for (int a = 0; a < 4; a++) read_chk(1'b0, 0, a, 8'h10 + a, "D rd_data");
    read_chk(1'b0, 1, 0, 8'h80, "B rd_data");

    // Commit and ack in the same edge: count holds, both pointers move.
    send_frame(1'b0, 8, 8'h70, 0, 2'b11, 1'b1);
    chk("cmt+ack rdy_valid", b2.rdy_valid, 1);
    chk("cmt+ack rdy_slot",  b2.rdy_slot,  1);
    chk("cmt+ack rdy_len",   b2.rdy_len,   4);
    ack_once(1'b0);
    chk("cmt+ack drained", b2.rdy_valid, 0);

    // Oversize frame lands in slot 1 while slot 0 holds a ready frame.
    send_frame(1'b0, 12, 8'h20, 0, 2'b11, 1'b0);
    chk("F rdy_slot", b2.rdy_slot, 0);
    chk("F rdy_len",  b2.rdy_len,  8);
    send_frame(1'b0, 1600, 8'h00, 0, 2'b11, 1'b0);
    exp_drops++;
    chk("oversize drop_pulse", b2.drop_pulse, 1);
    chk("oversize drop_count", b2.drop_count, exp_drops);
    chk("oversize rdy_slot",   b2.rdy_slot,   0);
    chk("oversize rdy_len",    b2.rdy_len,    8);
    for (int a = 0; a < 8; a++) read_chk(1'b0, 0, a, 8'h20 + a, "slot0 intact");
    read_chk(1'b0, 1, 1517, 8'hED, "oversize last byte");
    ack_once(1'b0);
    chk("oversize drained", b2.rdy_valid, 0);

    // DW=4: readback, then reset in the middle of a frame.
    send_frame(1'b1, 32, 8'h50, 0, 2'b11, 1'b0);
    chk("dw4 rdy_valid", b4.rdy_valid, 1);
    chk("dw4 rdy_slot",  b4.rdy_slot,  0);
    chk("dw4 rdy_len",   b4.rdy_len,   28);
    for (int a = 0; a < 28; a++) read_chk(1'b1, 0, a, 8'h50 + a, "dw4 rd_data");
    ack_once(1'b1);
    chk("dw4 ack rdy_slot", b4.rdy_slot, 1);
    saw_drop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 4'(i));
      step();
    end
    rst4 = 1'b1;
    step();
    drive(1'b1, 1'b0, 4'h0);
    step();
    chk("midrst rdy_valid",  b4.rdy_valid,  0);
    chk("midrst rdy_slot",   b4.rdy_slot,   0);
    chk("midrst rdy_len",    b4.rdy_len,    0);
    chk("midrst rd_data",    b4.rd_data,    0);
    chk("midrst drop_count", b4.drop_count, 0);
    rst4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (b4.drop_pulse) saw_drop = 1'b1;
    end
    chk("midrst no drop_pulse", int'(saw_drop), 0);
    send_frame(1'b1, 16, 8'h60, 0, 2'b11, 1'b0);
    chk("post-rst rdy_valid",  b4.rdy_valid,  1);
    chk("post-rst rdy_slot",   b4.rdy_slot,   0);
    chk("post-rst rdy_len",    b4.rdy_len,    12);
    chk("post-rst drop_count", b4.drop_count, 0);
    for (int a = 0; a < 4; a++) read_chk(1'b1, 0, a, 8'h60 + a, "post-rst rd_data");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
